// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: widths, state
// encodings, the IO region selector and the load/store length decode.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_WID          = 32;
  localparam int unsigned ICACHE_LINE_WID   = 512;
  localparam int unsigned ICACHE_LINE_BYTES = 64;

  typedef logic [ADDR_WID-1:0] addr_t;

  localparam logic [2:0] MC_IDLE  = 3'd0;
  localparam logic [2:0] MC_IF_RD = 3'd1;
  localparam logic [2:0] MC_LS_RD = 3'd2;
  localparam logic [2:0] MC_LS_WR = 3'd3;
  localparam logic [2:0] MC_DONE  = 3'd4;

  // Address bits [17:16] of the memory-mapped UART region.
  localparam logic [1:0] IO_REGION_SEL = 2'b11;

  // Byte count of a load/store; the illegal size 3 is treated as a word.
  function automatic logic [2:0] lsb_len(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serialises load/store and icache line-fill requests onto the byte-wide RAM.
// Optional macro MEM_CTRL_IO_STALL_EN holds IO-region stores while the UART buffer is full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned LINE_BYTES = ICACHE_LINE_BYTES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_WID-1:0]     mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    if_en,
  input  logic [ADDR_WID-1:0]     if_pc,
  output logic                    if_done,
  output logic [8*LINE_BYTES-1:0] if_data,
  input  logic                    lsb_en,
  input  logic                    lsb_wr,
  input  logic [ADDR_WID-1:0]     lsb_addr,
  input  logic [1:0]              lsb_size,
  input  logic [31:0]             lsb_wdata,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata
);

  localparam int unsigned CntW = $clog2(LINE_BYTES + 1);

  logic [2:0]              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [CntW-1:0]         len_q, len_d;
  addr_t                   base_q, base_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [8*LINE_BYTES-1:0] line_q, line_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    if_done_q, if_done_d;
  logic                    lsb_done_q, lsb_done_d;

  addr_t           byte_addr;
  logic [CntW-1:0] slot;
  logic            io_hold;

  assign byte_addr = base_q + ADDR_WID'(cnt_q);
  assign slot      = cnt_q - CntW'(1);

`ifdef MEM_CTRL_IO_STALL_EN
  assign io_hold = (state_q == MC_LS_WR) && (byte_addr[17:16] == IO_REGION_SEL) &&
                   io_buffer_full;
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_hold = 1'b0;
`endif

  always_comb begin
    mem_wr   = 1'b0;
    mem_a    = '0;
    mem_dout = '0;
    if (state_q == MC_LS_WR && !io_hold) begin
      mem_wr   = 1'b1;
      mem_a    = byte_addr;
      mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    end else if ((state_q == MC_IF_RD || state_q == MC_LS_RD) && cnt_q < len_q) begin
      mem_a = byte_addr;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    line_d     = line_q;
    rdata_d    = rdata_q;
    if_done_d  = 1'b0;
    lsb_done_d = 1'b0;
    case (state_q)
      MC_IDLE: begin
        if (!rollback) begin
          if (lsb_en) begin
            state_d = lsb_wr ? MC_LS_WR : MC_LS_RD;
            base_d  = lsb_addr;
            wdata_d = lsb_wdata;
            len_d   = CntW'(lsb_len(lsb_size));
            cnt_d   = '0;
            rdata_d = '0;
          end else if (if_en) begin
            state_d = MC_IF_RD;
            base_d  = if_pc;
            len_d   = CntW'(LINE_BYTES);
            cnt_d   = '0;
          end
        end
      end
      MC_IF_RD, MC_LS_RD: begin
        if (rollback) begin
          state_d = MC_IDLE;
        end else begin
          // mem_din carries the byte addressed one cycle earlier, i.e. slot cnt-1.
          if (cnt_q != '0) begin
            if (state_q == MC_IF_RD) line_d[{slot, 3'b000} +: 8] = mem_din;
            else                     rdata_d[{slot[1:0], 3'b000} +: 8] = mem_din;
          end
          if (cnt_q == len_q) begin
            state_d    = MC_DONE;
            if_done_d  = (state_q == MC_IF_RD);
            lsb_done_d = (state_q == MC_LS_RD);
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      MC_LS_WR: begin
        if (!io_hold) begin
          if (cnt_q == len_q - CntW'(1)) begin
            state_d    = MC_DONE;
            lsb_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      MC_DONE: state_d = MC_IDLE;
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MC_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      line_q     <= '0;
      rdata_q    <= '0;
      if_done_q  <= 1'b0;
      lsb_done_q <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      line_q     <= line_d;
      rdata_q    <= rdata_d;
      if_done_q  <= if_done_d;
      lsb_done_q <= lsb_done_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_data   = line_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomized bench for mem_ctrl against a byte-array memory model.
module tb_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst, rdy, rollback;
  logic [7:0]   mem_din = 8'h00;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         io_buffer_full;
  logic         if_en;
  logic [31:0]  if_pc;
  logic         if_done;
  logic [511:0] if_data;
  logic         lsb_en, lsb_wr;
  logic [31:0]  lsb_addr;
  logic [1:0]   lsb_size;
  logic [31:0]  lsb_wdata;
  logic         lsb_done;
  logic [31:0]  lsb_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] exp_mem [logic [31:0]];

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rollback       (rollback),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .if_en          (if_en),
    .if_pc          (if_pc),
    .if_done        (if_done),
    .if_data        (if_data),
    .lsb_en         (lsb_en),
    .lsb_wr         (lsb_wr),
    .lsb_addr       (lsb_addr),
    .lsb_size       (lsb_size),
    .lsb_wdata      (lsb_wdata),
    .lsb_done       (lsb_done),
    .lsb_rdata      (lsb_rdata)
  );

  always #5 clk = ~clk;

  // Initial RAM contents before any store touches a location.
  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[23:16] ^ a[31:24];
  endfunction

  function automatic logic [7:0] mrd(input logic [31:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return dflt(a);
  endfunction

  // Byte-serial RAM: read data one cycle after its address, frozen with rdy.
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram.exists(mem_a) ? ram[mem_a] : dflt(mem_a);
      if (mem_wr) ram[mem_a] = mem_dout;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one request in the current cycle and follows it to its done pulse.
  task automatic run_req(input bit is_if, input bit wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wd, input string tag);
    int n, k, exp_lat;
    bit seq_ok, done;
    logic [511:0] exp_data, got_data;
    n = is_if ? 64 : (size == 2'd0 ? 1 : (size == 2'd1 ? 2 : 4));
    exp_data = '0;
    for (int i = 0; i < n; i++) begin
      if (wr) exp_mem[addr + 32'(i)] = wd[8*i +: 8];
      else    exp_data[8*i +: 8] = mrd(addr + 32'(i));
    end
    if (is_if) begin
      if_en = 1'b1; if_pc = addr;
    end else begin
      lsb_en = 1'b1; lsb_wr = wr; lsb_addr = addr; lsb_size = size; lsb_wdata = wd;
    end
    exp_lat = wr ? n + 1 : n + 2;
    seq_ok = 1'b1;
    done = 1'b0;
    k = 0;
    while (!done && k < exp_lat + 8) begin
      step;
      k++;
      if (k <= n) begin
        if (wr) begin
          if (!(mem_wr && mem_a == addr + 32'(k-1) && mem_dout == wd[8*(k-1) +: 8]))
            seq_ok = 1'b0;
        end else if (mem_wr || mem_a != addr + 32'(k-1)) begin
          seq_ok = 1'b0;
        end
      end else if (mem_wr || mem_a != 32'h0 || mem_dout != 8'h0) begin
        seq_ok = 1'b0;
      end
      if (is_if ? lsb_done : if_done) seq_ok = 1'b0;
      done = is_if ? if_done : lsb_done;
    end
    got_data = is_if ? if_data : {480'b0, lsb_rdata};
    if (is_if) if_en = 1'b0;
    else       lsb_en = 1'b0;
    check({tag, "_lat"}, k, exp_lat);
    check({tag, "_bus"}, seq_ok, 1);
    if (!wr) check({tag, "_data"}, got_data, exp_data);
    step;
    check({tag, "_pulse"}, {if_done, lsb_done}, 0);
  endtask

  initial begin
    int k, first_wr, n_wr, exp_first, exp_done;
    bit flag, done;
    logic [31:0] a, saved_a, wd;
    logic [511:0] exp_data;

    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    if_en = 1'b0; if_pc = '0; lsb_en = 1'b0; lsb_wr = 1'b0;
    lsb_addr = '0; lsb_size = '0; lsb_wdata = '0;
    step;
    step;
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wr_dout", {mem_wr, mem_dout}, 0);
    check("rst_done", {if_done, lsb_done}, 0);
    check("rst_if_data", if_data, 0);
    check("rst_lsb_rdata", lsb_rdata, 0);
    rst = 1'b0;

    // Line fill of 0x1040: RAM there holds the low address byte.
    run_req(1'b1, 1'b0, 32'h0000_1040, 2'd0, 32'h0, "fill");
    check("fill_byte5", if_data[47:40], 8'h45);

    run_req(1'b0, 1'b1, 32'h0000_0200, 2'd2, 32'h4433_2211, "st_word");

    // Both requesters active: the load goes first, the fill right after DONE.
    if_en = 1'b1;
    if_pc = 32'h0000_0A00;
    run_req(1'b0, 1'b0, 32'h0000_0200, 2'd2, 32'h0, "prio_ld");
    check("prio_ld_lit", lsb_rdata, 32'h4433_2211);
    run_req(1'b1, 1'b0, 32'h0000_0A00, 2'd0, 32'h0, "prio_fill");

    run_req(1'b0, 1'b1, 32'h0000_0101, 2'd1, 32'h0000_BEEF, "st_half");
    run_req(1'b0, 1'b0, 32'h0000_0101, 2'd1, 32'h0, "ld_half");
    check("ld_half_lit", lsb_rdata, 32'h0000_BEEF);

    // Rollback in cycle C+20 of a fill, then a new fill accepted in C+21.
    if_en = 1'b1;
    if_pc = 32'h0000_2000;
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (if_done) flag = 1'b1;
    end
    check("rb_addr_c20", mem_a, 32'h0000_2013);
    rollback = 1'b1;
    step;
    rollback = 1'b0;
    check("rb_no_done", {flag, if_done}, 0);
    check("rb_idle_addr", mem_a, 0);
    run_req(1'b1, 1'b0, 32'h0000_3040, 2'd0, 32'h0, "rb_fill");

    // Store byte into the IO region with the UART buffer full for 5 cycles.
`ifdef MEM_CTRL_IO_STALL_EN
    exp_first = 6;
`else
    exp_first = 1;
`endif
    exp_done = exp_first + 1;
    exp_mem[32'h0003_0000] = 8'h5A;
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h0003_0000; lsb_size = 2'd0;
    lsb_wdata = 32'h0000_005A;
    io_buffer_full = 1'b1;
    k = 0; first_wr = 0; n_wr = 0; done = 1'b0;
    while (!done && k < 30) begin
      step;
      k++;
      if (k == 6) begin
        io_buffer_full = 1'b0;
        #1;
      end
      if (mem_wr) begin
        n_wr++;
        if (first_wr == 0) first_wr = k;
      end
      done = lsb_done;
    end
    lsb_en = 1'b0;
    io_buffer_full = 1'b0;
    check("io_first_wr", first_wr, exp_first);
    check("io_n_wr", n_wr, 1);
    check("io_done", k, exp_done);
    step;
    run_req(1'b0, 1'b0, 32'h0003_0000, 2'd0, 32'h0, "io_ld");

    // rdy low during cycles C+2..C+4 of a word load.
    a = 32'h0000_0480;
    exp_data = '0;
    for (int i = 0; i < 4; i++) exp_data[8*i +: 8] = mrd(a + 32'(i));
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = a; lsb_size = 2'd2;
    step;
    step;
    saved_a = mem_a;
    check("rdy_pre_addr", saved_a, a + 32'd1);
    rdy = 1'b0;
    k = 2;
    flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      k++;
      if (mem_a != saved_a || mem_wr || lsb_done || lsb_rdata != 32'h0) flag = 1'b0;
    end
    rdy = 1'b1;
    check("rdy_frozen", flag, 1);
    done = 1'b0;
    while (!done && k < 20) begin
      step;
      k++;
      done = lsb_done;
    end
    lsb_en = 1'b0;
    check("rdy_done_lat", k, 9);
    check("rdy_data", {480'b0, lsb_rdata}, exp_data);
    step;

    // Randomized mix; half the accesses land in a small window to revisit stores.
    for (int it = 0; it < 40; it++) begin
      int typ;
      logic [1:0] sz;
      typ = $urandom_range(0, 2);
      a   = (it % 2 == 0) ? $urandom : ($urandom & 32'h0000_03FF);
      if (it % 8 == 3) a = 32'hFFFF_FFFE;
      sz  = 2'($urandom_range(0, 2));
      wd  = $urandom;
      case (typ)
        0:       run_req(1'b1, 1'b0, a & ~32'h3F, 2'd0, 32'h0, $sformatf("rnd%0d_fill", it));
        1:       run_req(1'b0, 1'b0, a, sz, 32'h0, $sformatf("rnd%0d_ld", it));
        default: run_req(1'b0, 1'b1, a, sz, wd, $sformatf("rnd%0d_st", it));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
